// File: rtl/sdram_cpu32_bridge_if.sv
// Bus bundle between the SH-2 32-bit side and one 16-bit SDRAM controller channel.
// The bridge takes the slave view; the CPU/controller side takes the master view.
interface sdram_cpu32_bridge_if;
  logic [24:1] cpu_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic [24:1] sd_addr;
  logic        sd_rd;
  logic [1:0]  sd_wr;
  logic [15:0] sd_din;
  logic [15:0] sd_dout;
  logic        sd_busy;

  modport slave (
    input  cpu_addr, cpu_req, cpu_we, cpu_be, cpu_din, sd_dout, sd_busy,
    output cpu_dout, cpu_ack, sd_addr, sd_rd, sd_wr, sd_din
  );

  modport master (
    output cpu_addr, cpu_req, cpu_we, cpu_be, cpu_din, sd_dout, sd_busy,
    input  cpu_dout, cpu_ack, sd_addr, sd_rd, sd_wr, sd_din
  );
endinterface

// File: rtl/sdram_cpu32_bridge.sv
// Splits 32-bit SH-2 accesses into high-then-low 16-bit SDRAM channel transactions.
// state | meaning: IDLE = wait for request | ISSUE = strobe out | WAIT = channel busy
module sdram_cpu32_bridge #(
  parameter bit WBUF = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  sdram_cpu32_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q;
  logic [24:2] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] din_q;
  logic [31:0] stage_q;
  logic        half_q;
  logic [24:1] sd_addr_q;
  logic        sd_rd_q;
  logic [1:0]  sd_wr_q;
  logic [15:0] sd_din_q;
  logic [31:0] cpu_dout_q;
  logic        cpu_ack_q;

  logic        in_idle;
  logic        accept;
  logic        wait_done;
  logic        issue;
  logic [24:2] iss_addr;
  logic        iss_we;
  logic [3:0]  iss_be;
  logic [31:0] iss_din;
  logic        iss_half;
  logic [31:0] stage_d;
  logic        unused_addr_bit;

  assign unused_addr_bit = bus.cpu_addr[1];

  assign in_idle   = (state_q == IDLE);
  assign accept    = in_idle && bus.cpu_req && !cpu_ack_q && !bus.sd_busy;
  assign wait_done = (state_q == WAIT) && !bus.sd_busy;
  assign issue     = (accept && (bus.cpu_be != 4'b0000)) ||
                     (wait_done && !half_q && (be_q[1:0] != 2'b00));

  // Fresh bus values on acceptance; captured values when moving on to the low half.
  assign iss_addr = in_idle ? bus.cpu_addr[24:2] : addr_q;
  assign iss_we   = in_idle ? bus.cpu_we : we_q;
  assign iss_be   = in_idle ? bus.cpu_be : be_q;
  assign iss_din  = in_idle ? bus.cpu_din : din_q;
  assign iss_half = in_idle ? (bus.cpu_be[3:2] == 2'b00) : 1'b1;

  assign stage_d = half_q ? {stage_q[31:16], bus.sd_dout} : {bus.sd_dout, stage_q[15:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      din_q      <= '0;
      stage_q    <= '0;
      half_q     <= 1'b0;
      sd_addr_q  <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 2'b00;
      sd_din_q   <= '0;
      cpu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 2'b00;

      if (issue) begin
        half_q    <= iss_half;
        sd_addr_q <= {iss_addr, iss_half};
        if (iss_we) begin
          sd_wr_q  <= iss_half ? iss_be[1:0] : iss_be[3:2];
          sd_din_q <= iss_half ? iss_din[15:0] : iss_din[31:16];
        end else begin
          sd_rd_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.cpu_addr[24:2];
            we_q    <= bus.cpu_we;
            be_q    <= bus.cpu_be;
            din_q   <= bus.cpu_din;
            stage_q <= '0;
            if (bus.cpu_be == 4'b0000) begin
              cpu_ack_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              // Posted write: the CPU is released while the halves run in the background.
              if (WBUF && bus.cpu_we) cpu_ack_q <= 1'b1;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (!bus.sd_busy) begin
            if (!we_q) stage_q <= stage_d;
            if (issue) begin
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
              if (!we_q) begin
                cpu_ack_q  <= 1'b1;
                cpu_dout_q <= stage_d;
              end else if (!WBUF) begin
                cpu_ack_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_rd    = sd_rd_q;
  assign bus.sd_wr    = sd_wr_q;
  assign bus.sd_din   = sd_din_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.cpu_ack  = cpu_ack_q;
endmodule
